fifo_sync_param: RTL

- Parametrised synchronous FIFO. Next generation of the team's 16x8 FIFO.
- Generalised in data width and depth.
- Adds simultaneous read/write in one cycle, programmable almost-full/almost-empty thresholds, an occupancy count output, and overflow/underflow error pulses.
- Sits between stimulus/driver logic and consumers on a single clock domain. Pairs with a matching interface for the layered testbench.

---
 rtl/fifo_sync_param.sv | 110 +++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO. Flags come from the registered count, reads
// have one cycle of latency, and refused requests raise registered error pulses.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_sync_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, underflow_q;
  logic             wr_acc, rd_acc;

  // wr/rd are request strobes sampled on each rising edge against the
  // pre-edge occupancy: a write is taken only when not full, a read only when
  // not empty; a refused request is dropped and flagged on overflow/underflow
  // for one cycle after that edge.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign dout         = dout_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc  = wr & ~full;
    rd_acc  = rd & ~empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    dout_d  = dout_q;
    if (wr_acc) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + AW'(1);
      dout_d = mem_q[rptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= wr & full;
      underflow_q <= rd & empty;
    end
  end

  // Storage is deliberately left unreset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule
